// File: rtl/arm_pipe_control.sv
// -----------------------------------------------------------------------------
// arm_pipe_control
// Pipelined main decoder for a 5-stage LEGv8 core. Decodes the instruction in
// IF/ID, detects load-use hazards, applies branch flush, and carries the
// control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   id_instr, id_valid    instruction held in IF/ID and its valid flag
//   ex_branch_taken       branch in EX resolved taken this cycle
//   stall                 load-use hazard: hold PC and IF/ID (combinational)
//   ifid_flush            clear IF/ID on the next edge (combinational)
//   illegal               registered one-cycle pulse for an unknown opcode
//   ex_*                  ID/EX register: ALU controls, branch flags, rd
//   mem_*                 EX/MEM register: memory controls, rd
//   wb_*                  MEM/WB register: writeback controls, rd
// -----------------------------------------------------------------------------
module arm_pipe_control #(
    parameter int OPC_W        = 11,
    parameter int REG_AW       = 5,
    parameter int ZERO_REG     = 31,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              ifid_flush,
    output logic              illegal,
    output logic [1:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_isZeroBranch,
    output logic              ex_isNotZeroBranch,
    output logic              ex_isUnconBranch,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_memRead,
    output logic              mem_memwrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_regwrite,
    output logic              wb_mem2reg,
    output logic [REG_AW-1:0] wb_rd
);

    localparam logic [REG_AW-1:0] ZERO_RD = ZERO_REG[REG_AW-1:0];
    localparam logic              TRAP_EN = (TRAP_ILLEGAL != 0);

    typedef struct packed {
        logic [1:0]        aluop;
        logic              alusrc;
        logic              zero_br;
        logic              nzero_br;
        logic              uncon_br;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem2reg;
        logic [REG_AW-1:0] rd;
    } ctl_t;

    // A bubble carries no side effects and targets XZR.
    function automatic ctl_t bubble_ctl();
        ctl_t c;
        c          = '0;
        c.rd       = ZERO_RD;
        return c;
    endfunction

    logic [OPC_W-1:0]  opcode_s;
    logic [REG_AW-1:0] rn_s;
    logic [REG_AW-1:0] rm_s;
    logic [REG_AW-1:0] rt_s;
    logic              unused_shamt_s;

    ctl_t dec_s;
    ctl_t idex_next_s;
    logic known_s;
    logic use_rn_s;
    logic use_rm_s;
    logic use_rt_s;
    logic hazard_s;
    logic stall_s;
    logic illegal_next_s;

    ctl_t              idex_r;
    logic              exmem_mem_read_r;
    logic              exmem_mem_write_r;
    logic              exmem_reg_write_r;
    logic              exmem_mem2reg_r;
    logic [REG_AW-1:0] exmem_rd_r;
    logic              memwb_reg_write_r;
    logic              memwb_mem2reg_r;
    logic [REG_AW-1:0] memwb_rd_r;
    logic              illegal_r;

    assign opcode_s       = id_instr[31:32-OPC_W];
    assign rn_s           = id_instr[9:5];
    assign rm_s           = id_instr[20:16];
    assign rt_s           = id_instr[4:0];
    // Shift-amount field has no role in control decode.
    assign unused_shamt_s = ^id_instr[15:10];

    // Main decode: prefix-matched branch/immediate classes first, then exact opcodes.
    always_comb begin
        dec_s    = bubble_ctl();
        known_s  = 1'b1;
        use_rn_s = 1'b0;
        use_rm_s = 1'b0;
        use_rt_s = 1'b0;
        if (opcode_s[10:5] == 6'b000101) begin
            dec_s.aluop    = 2'b01;
            dec_s.uncon_br = 1'b1;
        end else if (opcode_s[10:3] == 8'b10110100) begin
            dec_s.aluop    = 2'b01;
            dec_s.zero_br  = 1'b1;
            use_rt_s       = 1'b1;
        end else if (opcode_s[10:3] == 8'b10110101) begin
            dec_s.aluop    = 2'b01;
            dec_s.nzero_br = 1'b1;
            use_rt_s       = 1'b1;
        end else if (opcode_s[10:1] == 10'b1001000100) begin
            dec_s.reg_write = 1'b1;
            dec_s.alusrc    = 1'b1;
            dec_s.rd        = rt_s;
            use_rn_s        = 1'b1;
        end else begin
            case (opcode_s)
                11'b11111000010: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.mem2reg   = 1'b1;
                    dec_s.mem_read  = 1'b1;
                    dec_s.alusrc    = 1'b1;
                    dec_s.rd        = rt_s;
                    use_rn_s        = 1'b1;
                end
                11'b11111000000: begin
                    dec_s.mem_write = 1'b1;
                    dec_s.alusrc    = 1'b1;
                    use_rn_s        = 1'b1;
                    use_rt_s        = 1'b1;
                end
                11'b10001011000,
                11'b11001011000,
                11'b10001010000,
                11'b10101010000: begin
                    dec_s.reg_write = 1'b1;
                    dec_s.aluop     = 2'b10;
                    dec_s.rd        = rt_s;
                    use_rn_s        = 1'b1;
                    use_rm_s        = 1'b1;
                end
                default: begin
                    known_s = 1'b0;
                end
            endcase
        end
    end

    // Load-use detection; a taken branch flushes ID, so it overrides the stall.
    always_comb begin
        hazard_s = 1'b0;
        if (idex_r.mem_read && (idex_r.rd != ZERO_RD)) begin
            hazard_s = (use_rn_s && (rn_s == idex_r.rd)) ||
                       (use_rm_s && (rm_s == idex_r.rd)) ||
                       (use_rt_s && (rt_s == idex_r.rd));
        end else begin
            hazard_s = 1'b0;
        end
        stall_s        = id_valid && !ex_branch_taken && hazard_s;
        illegal_next_s = TRAP_EN && id_valid && !known_s && !ex_branch_taken;
    end

    // ID/EX input: decoded bundle, or a bubble when ID must not advance.
    always_comb begin
        idex_next_s = bubble_ctl();
        if (stall_s || ex_branch_taken || !id_valid || !known_s) begin
            idex_next_s = bubble_ctl();
        end else begin
            idex_next_s = dec_s;
        end
    end

    // Pipeline registers: shift every cycle, reset to bubbles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idex_r            <= bubble_ctl();
            exmem_mem_read_r  <= 1'b0;
            exmem_mem_write_r <= 1'b0;
            exmem_reg_write_r <= 1'b0;
            exmem_mem2reg_r   <= 1'b0;
            exmem_rd_r        <= ZERO_RD;
            memwb_reg_write_r <= 1'b0;
            memwb_mem2reg_r   <= 1'b0;
            memwb_rd_r        <= ZERO_RD;
            illegal_r         <= 1'b0;
        end else begin
            idex_r            <= idex_next_s;
            exmem_mem_read_r  <= idex_r.mem_read;
            exmem_mem_write_r <= idex_r.mem_write;
            exmem_reg_write_r <= idex_r.reg_write;
            exmem_mem2reg_r   <= idex_r.mem2reg;
            exmem_rd_r        <= idex_r.rd;
            memwb_reg_write_r <= exmem_reg_write_r;
            memwb_mem2reg_r   <= exmem_mem2reg_r;
            memwb_rd_r        <= exmem_rd_r;
            illegal_r         <= illegal_next_s;
        end
    end

    assign stall              = stall_s;
    assign ifid_flush         = ex_branch_taken;
    assign illegal            = illegal_r;
    assign ex_aluop           = idex_r.aluop;
    assign ex_alusrc          = idex_r.alusrc;
    assign ex_isZeroBranch    = idex_r.zero_br;
    assign ex_isNotZeroBranch = idex_r.nzero_br;
    assign ex_isUnconBranch   = idex_r.uncon_br;
    assign ex_rd              = idex_r.rd;
    assign mem_memRead        = exmem_mem_read_r;
    assign mem_memwrite       = exmem_mem_write_r;
    assign mem_rd             = exmem_rd_r;
    assign wb_regwrite        = memwb_reg_write_r;
    assign wb_mem2reg         = memwb_mem2reg_r;
    assign wb_rd              = memwb_rd_r;

endmodule

// File: tb/tb_arm_pipe_control.sv
// -----------------------------------------------------------------------------
// tb_arm_pipe_control
// Scoreboard bench: each driven instruction pushes its expected EX/MEM/WB
// outputs with the cycle they are due; they are popped and compared then.
// Expected bundle bits: [9:8] aluop [7] alusrc [6] cbz [5] cbnz [4] b
//                       [3] memRead [2] memwrite [1] regwrite [0] mem2reg
// -----------------------------------------------------------------------------
module tb_arm_pipe_control;

    localparam logic [9:0] C_NOP  = 10'b00_0_000_0_0_0_0;
    localparam logic [9:0] C_LDUR = 10'b00_1_000_1_0_1_1;
    localparam logic [9:0] C_STUR = 10'b00_1_000_0_1_0_0;
    localparam logic [9:0] C_RT   = 10'b10_0_000_0_0_1_0;
    localparam logic [9:0] C_ADDI = 10'b00_1_000_0_0_1_0;
    localparam logic [9:0] C_CBZ  = 10'b01_0_100_0_0_0_0;
    localparam logic [9:0] C_CBNZ = 10'b01_0_010_0_0_0_0;
    localparam logic [9:0] C_B    = 10'b01_0_001_0_0_0_0;

    logic        clk;
    logic        reset_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_branch_taken;
    logic        stall;
    logic        ifid_flush;
    logic        illegal;
    logic [1:0]  ex_aluop;
    logic        ex_alusrc;
    logic        ex_isZeroBranch;
    logic        ex_isNotZeroBranch;
    logic        ex_isUnconBranch;
    logic [4:0]  ex_rd;
    logic        mem_memRead;
    logic        mem_memwrite;
    logic [4:0]  mem_rd;
    logic        wb_regwrite;
    logic        wb_mem2reg;
    logic [4:0]  wb_rd;

    arm_pipe_control dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .id_instr           (id_instr),
        .id_valid           (id_valid),
        .ex_branch_taken    (ex_branch_taken),
        .stall              (stall),
        .ifid_flush         (ifid_flush),
        .illegal            (illegal),
        .ex_aluop           (ex_aluop),
        .ex_alusrc          (ex_alusrc),
        .ex_isZeroBranch    (ex_isZeroBranch),
        .ex_isNotZeroBranch (ex_isNotZeroBranch),
        .ex_isUnconBranch   (ex_isUnconBranch),
        .ex_rd              (ex_rd),
        .mem_memRead        (mem_memRead),
        .mem_memwrite       (mem_memwrite),
        .mem_rd             (mem_rd),
        .wb_regwrite        (wb_regwrite),
        .wb_mem2reg         (wb_mem2reg),
        .wb_rd              (wb_rd)
    );

    typedef struct {
        int         due;
        int         sel;
        logic [9:0] val;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence never completes.
    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {26'd0, ex_aluop, ex_alusrc, ex_isZeroBranch,
                             ex_isNotZeroBranch, ex_isUnconBranch};
            1:       return {27'd0, ex_rd};
            2:       return {30'd0, mem_memRead, mem_memwrite};
            3:       return {27'd0, mem_rd};
            4:       return {30'd0, wb_regwrite, wb_mem2reg};
            5:       return {27'd0, wb_rd};
            6:       return {31'd0, illegal};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input int due, input int sel, input logic [9:0] val, input string tag);
        exp_t e;
        e.due = due;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then compare every scoreboard entry that is due.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                check(sb_q[i].tag, obs(sb_q[i].sel), {22'd0, sb_q[i].val});
                sb_q.delete(i);
            end
        end
    endtask

    // Drive one ID cycle: check combinational stall/flush, queue the
    // expected bundle for EX (+1), MEM (+2) and WB (+3), then clock.
    task automatic step(input logic [31:0] ins, input logic v, input logic t,
                        input logic xs, input logic [9:0] ctl, input logic [4:0] rd,
                        input logic ill);
        id_instr        = ins;
        id_valid        = v;
        ex_branch_taken = t;
        #1;
        check("stall", {31'd0, stall}, {31'd0, xs});
        check("ifid_flush", {31'd0, ifid_flush}, {31'd0, t});
        push(cyc + 1, 0, {4'd0, ctl[9:4]}, "ex_ctl");
        push(cyc + 1, 1, {5'd0, rd},       "ex_rd");
        push(cyc + 1, 6, {9'd0, ill},      "illegal");
        push(cyc + 2, 2, {8'd0, ctl[3:2]}, "mem_ctl");
        push(cyc + 2, 3, {5'd0, rd},       "mem_rd");
        push(cyc + 3, 4, {8'd0, ctl[1:0]}, "wb_ctl");
        push(cyc + 3, 5, {5'd0, rd},       "wb_rd");
        tick();
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        cyc             = 0;
        reset_n         = 1'b0;
        id_instr        = 32'hF840_0025;
        id_valid        = 1'b1;
        ex_branch_taken = 1'b0;

        // Reset held two cycles with a load sitting in ID.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ex_ctl",  obs(0), 32'd0);
        check("rst_ex_rd",   obs(1), 32'd31);
        check("rst_mem_ctl", obs(2), 32'd0);
        check("rst_mem_rd",  obs(3), 32'd31);
        check("rst_wb_ctl",  obs(4), 32'd0);
        check("rst_wb_rd",   obs(5), 32'd31);
        check("rst_illegal", obs(6), 32'd0);
        check("rst_stall",   {31'd0, stall}, 32'd0);
        check("rst_flush",   {31'd0, ifid_flush}, 32'd0);
        reset_n = 1'b1;

        //    instr         v     taken stall ctl     rd     ill
        step(32'h8B02_0023, 1'b1, 1'b0, 1'b0, C_RT,   5'd3,  1'b0); // ADD X3,X1,X2
        step(32'hF840_0025, 1'b1, 1'b0, 1'b0, C_LDUR, 5'd5,  1'b0); // LDUR X5,[X1]
        step(32'h8B07_00A6, 1'b1, 1'b0, 1'b1, C_NOP,  5'd31, 1'b0); // ADD X6,X5,X7 stalls
        step(32'h8B07_00A6, 1'b1, 1'b0, 1'b0, C_RT,   5'd6,  1'b0); // ADD retried
        step(32'hF840_003F, 1'b1, 1'b0, 1'b0, C_LDUR, 5'd31, 1'b0); // LDUR X31,[X1]
        step(32'h8B01_03E6, 1'b1, 1'b0, 1'b0, C_RT,   5'd6,  1'b0); // ADD X6,X31,X1: XZR exempt
        step(32'hF840_0025, 1'b1, 1'b0, 1'b0, C_LDUR, 5'd5,  1'b0); // LDUR X5,[X1]
        step(32'h8B07_00A6, 1'b1, 1'b1, 1'b0, C_NOP,  5'd31, 1'b0); // flush beats load-use
        step(32'hB500_0005, 1'b1, 1'b0, 1'b0, C_CBNZ, 5'd31, 1'b0); // CBNZ X5
        step(32'h8B07_00A6, 1'b1, 1'b1, 1'b0, C_NOP,  5'd31, 1'b0); // CBNZ taken in EX
        step(32'hF800_0044, 1'b1, 1'b0, 1'b0, C_STUR, 5'd31, 1'b0); // STUR X4,[X2]
        step(32'hF840_0044, 1'b1, 1'b0, 1'b0, C_LDUR, 5'd4,  1'b0); // LDUR X4,[X2]
        step(32'hF800_0044, 1'b1, 1'b0, 1'b1, C_NOP,  5'd31, 1'b0); // STUR Rt hazard
        step(32'hF800_0044, 1'b1, 1'b0, 1'b0, C_STUR, 5'd31, 1'b0); // STUR retried
        step(32'hFFE0_0000, 1'b1, 1'b0, 1'b0, C_NOP,  5'd31, 1'b1); // opcode 0x7FF
        step(32'h9100_0422, 1'b1, 1'b0, 1'b0, C_ADDI, 5'd2,  1'b0); // ADDI X2,X1,#1
        step(32'hB400_0003, 1'b1, 1'b0, 1'b0, C_CBZ,  5'd31, 1'b0); // CBZ X3
        step(32'h1400_0010, 1'b1, 1'b0, 1'b0, C_B,    5'd31, 1'b0); // B
        step(32'h8B02_0023, 1'b0, 1'b0, 1'b0, C_NOP,  5'd31, 1'b0); // invalid slot
        step(32'hF840_0027, 1'b1, 1'b0, 1'b0, C_LDUR, 5'd7,  1'b0); // LDUR X7,[X1]
        step(32'hB400_0007, 1'b1, 1'b0, 1'b1, C_NOP,  5'd31, 1'b0); // CBZ X7 stalls
        step(32'hB400_0007, 1'b1, 1'b0, 1'b0, C_CBZ,  5'd31, 1'b0); // CBZ retried

        id_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_pipe_control.md
Name: arm_pipe_control

Overview:
- Pipelined successor to the single-cycle ARM main decoder.
- Decodes the 11-bit opcode field of the instruction in ID, then carries the control bundle through ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use hazard stalling, branch flush, CBNZ and ADDI decode, and a defined illegal-opcode response (bubble plus flag) instead of X outputs.
- Sits between the IF/ID register and the datapath pipeline registers of the 5-stage LEGv8 core.

Parameters:
- OPC_W, 11, width of the decoded opcode field (instr[31:21]).
- REG_AW, 5, register address width.
- ZERO_REG, 31, register index of XZR; never a hazard source.
- TRAP_ILLEGAL, 1, 1 = illegal opcode raises `illegal`; 0 = decode silently as NOP.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `id_instr` in 32: instruction currently held in IF/ID.
- `id_valid` in 1: IF/ID holds a real instruction.
- `ex_branch_taken` in 1: branch in EX resolved taken this cycle.
- `stall` out 1: load-use hazard; hold PC and IF/ID.
- `ifid_flush` out 1: clear IF/ID on the next edge.
- `illegal` out 1: registered, pulses one cycle for an unknown opcode.
- `ex_aluop` out 2: ALU op for EX (00 add, 01 pass/zero-test, 10 funct-decode).
- `ex_alusrc` out 1: ALU B operand is the immediate.
- `ex_isZeroBranch` out 1: CBZ in EX.
- `ex_isNotZeroBranch` out 1: CBNZ in EX.
- `ex_isUnconBranch` out 1: B in EX.
- `ex_rd` out REG_AW: destination register of the EX instruction.
- `mem_memRead` out 1: load in MEM.
- `mem_memwrite` out 1: store in MEM.
- `mem_rd` out REG_AW: destination register of the MEM instruction.
- `wb_regwrite` out 1: register write in WB.
- `wb_mem2reg` out 1: WB data comes from memory.
- `wb_rd` out REG_AW: destination register of the WB instruction.

Behaviour:
- Decode (combinational, ID), opcode = instr[31:21]:
  - B = [31:26]=000101.
  - CBZ = [31:24]=10110100.
  - CBNZ = [31:24]=10110101.
  - ADDI = [31:22]=1001000100.
  - LDUR = 11111000010, STUR = 11111000000.
  - ADD = 10001011000, SUB = 11001011000, AND = 10001010000, ORR = 10101010000.
  - Match priority is B, CBZ, CBNZ, ADDI, then the exact 11-bit compares.
- Control values per class:
  - LDUR: regwrite, mem2reg, memRead, alusrc, aluop 00.
  - STUR: memwrite, alusrc, aluop 00.
  - R-type: regwrite, aluop 10.
  - ADDI: regwrite, alusrc, aluop 00.
  - CBZ/CBNZ: aluop 01, matching branch flag.
  - B: aluop 01, isUncon.
  - Any unset control is 0; the block never outputs X.
- Destination register: rd = instr[4:0] for LDUR/R-type/ADDI. Stores, branches and NOPs carry rd = ZERO_REG and regwrite 0.
- Source registers:
  - Rn = instr[9:5], used by LDUR/STUR/R-type/ADDI.
  - R-type: Rm = instr[20:16].
  - STUR/CBZ/CBNZ: Rt = instr[4:0].
- Load-use hazard: `stall` = id_valid & ID/EX.memRead & ID/EX.rd != ZERO_REG & (ID/EX.rd == any used source of ID).
- Timing: each pipeline register shifts every cycle. Outputs `ex_*` are the ID/EX register, `mem_*` the EX/MEM register, `wb_*` the MEM/WB register.
  - A decoded instruction appears on `ex_*` 1 cycle after it is present in ID, on `mem_*` after 2 cycles, on `wb_*` after 3 cycles.
- ID/EX loads a bubble (all control 0, rd = ZERO_REG) when any of these holds: `stall`, `ex_branch_taken`, !id_valid, or illegal.
- Flush:
  - `ifid_flush` = `ex_branch_taken` (combinational).
  - Flush has priority: when `ex_branch_taken` is high, `stall` is forced to 0 in the same cycle.
  - The EX branch instruction itself continues to MEM normally.
- Stall: EX/MEM and MEM/WB keep advancing. A stall lasts exactly 1 cycle per load-use pair, because the bubble removes the match.
- Illegal opcode: with TRAP_ILLEGAL=1, `illegal` goes high for 1 cycle, coincident with the bubble on `ex_*`. With TRAP_ILLEGAL=0, `illegal` stays 0.
- Reset (`reset_n`=0 at a rising edge):
  - All pipeline registers become bubbles: control outputs 0, rd outputs = ZERO_REG, `illegal` = 0.
  - `stall` and `ifid_flush` are combinational, so they read 0 once the registers are cleared.
  - Reset mid-stall or mid-flush discards all in-flight instructions.

Test Plan:
- Reset: hold `reset_n`=0 for 2 cycles with LDUR in ID. Then all outputs are 0, rd outputs are 31, and `stall`=0.
- Latency: ADD X3,X1,X2 (0x8B020023) with id_valid=1. `ex_aluop`=10 and `ex_rd`=3 at cycle+1, `wb_regwrite`=1 and `wb_rd`=3 at cycle+3.
- Load-use: LDUR X5 followed by ADD X6,X5,X7. `stall`=1 for exactly 1 cycle, `ex_*` shows a bubble, then ADD reaches EX with `ex_rd`=6.
- XZR exemption: LDUR X31 followed by ADD X6,X31,X1. `stall` never asserts.
- Flush priority: CBNZ taken in EX while ID holds a load-use-dependent ADD. `ifid_flush`=1, `stall`=0, next `ex_*` is a bubble, and `mem_*` carries the CBNZ.
- Illegal: opcode 0x7FF with TRAP_ILLEGAL=1. `illegal` pulses 1 cycle, `ex_*` controls are all 0, and `wb_regwrite` stays 0.
